// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: word width, opcode map, fetch state and the IF/ID entry.
package mips32_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [5:0] {
    OPC_ADD   = 6'h00,
    OPC_SUB   = 6'h01,
    OPC_AND   = 6'h02,
    OPC_OR    = 6'h03,
    OPC_SLT   = 6'h04,
    OPC_MUL   = 6'h05,
    OPC_LW    = 6'h08,
    OPC_SW    = 6'h09,
    OPC_ADDI  = 6'h0A,
    OPC_SUBI  = 6'h0B,
    OPC_SLTI  = 6'h0C,
    OPC_BNEQZ = 6'h0D,
    OPC_BEQZ  = 6'h0E,
    OPC_HLT   = 6'h3F
  } opcode_e;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    word_t ir;
    word_t npc;
  } if_entry_t;

  function automatic logic is_hlt(input logic [5:0] opc);
    return opc == OPC_HLT;
  endfunction

endpackage

// File: rtl/mips32_ifetch_if.sv
// Instruction-memory bus and IF/ID handshake of the fetch unit.
interface mips32_ifetch_if;
  import mips32_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  word_t imem_rdata;
  logic  if_valid;
  logic  if_ready;
  word_t if_ir;
  word_t if_npc;

  modport master (
    output imem_req, imem_addr, if_valid, if_ir, if_npc,
    input  imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_ir, if_npc,
    output imem_rdata, if_ready
  );

endinterface

// File: rtl/mips32_fetch_fifo.sv
// Prefetch queue of IF/ID entries; flush empties it in one edge and wins over push/pop.
module mips32_fetch_fifo
  import mips32_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  if_entry_t        push_data,
  input  logic             pop,
  output if_entry_t        head,
  output logic [CNT_W-1:0] count
);

  if_entry_t        mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign wr_en = push && !flush;
  assign rd_en = pop && !flush;

  // NOTE: storage is deliberately not reset; an empty queue is defined by count,
  // and the consumer masks the head when count is zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/mips32_ifetch.sv
// Word-addressed instruction fetch with credit-based prefetch, redirect squash and HLT stop.
module mips32_ifetch
  import mips32_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = '0
) (
  input  logic            clk1,
  input  logic            rst_n,
  mips32_ifetch_if.master bus,
  input  logic            redirect,
  input  word_t           redirect_pc,
  output logic            halted
);

  localparam int             CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  fetch_state_e     state_q, state_d;
  word_t            fetch_pc_q, fetch_pc_d;
  word_t            inflight_addr_q, inflight_addr_d;
  logic             inflight_q, inflight_d;
  logic             req, push, pop, valid, hlt_seen;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  if_entry_t        push_data, head;

  // Queued entries plus the one in flight must never exceed the queue size.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_q);
  assign halted    = (state_q == FETCH_HALT);
  assign req       = rst_n && !redirect && !halted && (occupancy < DEPTH_C);

  // A response is dropped if a redirect squashes it or a HLT was already taken.
  assign push      = inflight_q && !redirect && !halted;
  assign pop       = valid && bus.if_ready && !redirect;
  assign push_data = '{ir: bus.imem_rdata, npc: inflight_addr_q + 32'd1};
  assign hlt_seen  = push && is_hlt(bus.imem_rdata[31:26]);

  assign valid         = (count != '0);
  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.if_valid  = valid;
  assign bus.if_ir     = valid ? head.ir  : '0;
  assign bus.if_npc    = valid ? head.npc : '0;

  mips32_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk1),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = req;
    inflight_addr_d = inflight_addr_q;
    if (redirect) begin
      state_d    = FETCH_RUN;
      fetch_pc_d = redirect_pc;
    end else begin
      if (hlt_seen) state_d = FETCH_HALT;
      if (req) begin
        fetch_pc_d      = fetch_pc_q + 32'd1;
        inflight_addr_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= FETCH_RUN;
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

endmodule

// File: doc/mips32_ifetch.md
MIPS32_IFETCH -- requirements
Module: mips32_ifetch

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0, first word address fetched after reset.
REQ-003 Port clk1  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port imem_req  output  1  instruction-memory read request this cycle.
REQ-006 Port imem_addr  output  32  word address of the request.
REQ-007 Port imem_rdata  input  32  read data, valid exactly one cycle after an accepted request.
REQ-008 Port redirect  input  1  taken-branch redirect from EX/MEM.
REQ-009 Port redirect_pc  input  32  branch target word address, sampled when redirect=1.
REQ-010 Port if_valid  output  1  IF/ID entry available.
REQ-011 Port if_ready  input  1  ID stage accepts entry; a pop occurs when if_valid and if_ready are both 1.
REQ-012 Port if_ir  output  32  instruction at queue head.
REQ-013 Port if_npc  output  32  word address of head instruction plus 1.
REQ-014 Port halted  output  1  HLT fetched; fetching stopped.

Function
REQ-015 Addressing is word-granular: sequential fetch PC increments by 1, and npc = fetch address + 1 (32-bit wrap at 32'hFFFFFFFF -> 0).
REQ-016 imem_req = !redirect && !halted && (count + inflight < DEPTH); imem_addr = fetch_pc.
REQ-017 On an accepted request, fetch_pc advances by 1 and inflight is set for the next cycle.
REQ-018 An inflight response is pushed as {imem_rdata, addr+1} unless squashed.
REQ-019 Queue is FIFO; if_ir/if_npc reflect the head entry combinationally; if_valid = (count != 0).
REQ-020 Push and pop in the same cycle leave count unchanged; the credit rule in REQ-016 guarantees no overflow, and no pop occurs when the queue is empty.
REQ-021 HLT detection: a pushed instruction with opcode bits [31:26] = 6'h3F sets halted on that edge; the HLT itself is queued; later responses are discarded.
REQ-022 Redirect has priority over all other events in the same cycle: the queue is flushed, a pop in that cycle has no effect, the inflight response is squashed, halted is cleared, and fetch_pc is loaded with redirect_pc.
REQ-023 The cycle after a redirect: if_valid=0, imem_req=1 with imem_addr=redirect_pc (unless redirect is asserted again).
REQ-024 Back-to-back redirects: the last redirect_pc wins; no instruction from an earlier target is ever delivered.
REQ-025 Steady-state throughput with if_ready=1 constantly is one instruction per cycle once the queue is non-empty.
REQ-026 Latency: a request issued in cycle N makes the instruction visible at if_valid in cycle N+2 when the queue was empty.

Reset
REQ-027 While rst_n=0: fetch_pc=RESET_PC, count=0, inflight=0, halted=0, if_valid=0, imem_req=0, if_ir=0, if_npc=0.
REQ-028 An assertion of rst_n mid-operation discards queue contents and inflight data immediately, without waiting for a clock edge.
REQ-029 In the first cycle after rst_n deasserts, imem_req=1 with imem_addr=RESET_PC.

Structure
REQ-030 Shared package mips32_pkg holds WORD_W=32, the opcode constants (OPC_HLT=6'h3F, OPC_ADDI=6'h0A, OPC_ADD, OPC_OR, branch opcodes), and the IF/ID entry type {ir, npc}.
REQ-031 The queue is sub-module mips32_fetch_fifo (DEPTH, push/pop/flush, count); fetch control, credits, squash and halt logic stay in mips32_ifetch.

Verification
REQ-032 Sequential fetch: memory holds 2801000a, 28020014, 28030019, 00222000 at words 0..3, if_ready=1 -> ir sequence in that order with npc 1,2,3,4, and if_valid first high in the 2nd cycle after reset.
REQ-033 Backpressure: if_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, imem_req=0 thereafter; on release, words 0..3 are popped then fetch resumes at word 4 with no gaps or duplicates.
REQ-034 Halt: word 8 = fc000000 -> halted=1 after the HLT is pushed, no entry beyond word 8 delivered, and imem_req stays 0 for 20 cycles.
REQ-035 Redirect: redirect=1 with redirect_pc=32'h20 while the queue holds 3 entries and a request is inflight, plus a simultaneous pop -> next cycle if_valid=0 and imem_addr=32'h20; the next delivered ir = Mem[32], npc=32'h21.
REQ-036 Redirect clears halt: after halted=1, redirect_pc=32'h5 -> halted=0 and delivery resumes from Mem[5].
REQ-037 Reset mid-stream: rst_n pulsed low for half a cycle while 2 entries are queued -> if_valid drops immediately, and fetch restarts at RESET_PC.
